// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- 32 x 32-bit general register file, two read ports, one write
// port, with a self-clearing sweep after reset.
//
// Ports:
//   clk          sole clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   read_en_1    read port 1 enable
//   read_addr_1  read port 1 register index
//   read_data_1  read port 1 data (combinational, same cycle)
//   read_en_2    read port 2 enable
//   read_addr_2  read port 2 register index
//   read_data_2  read port 2 data (combinational, same cycle)
//   write_en     write port enable
//   write_addr   write port register index (index 0 is discarded)
//   write_data   write port data
//   busy         high while the clear sweep runs; driven from state only
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   : a read of the register being written this cycle returns
//               write_data (write-before-read).
//   undefined : such a read returns the stored (pre-write) value.
//
// After reset the FSM sits in CLEAR and writes zero to one register per
// cycle (index 0..31), then moves to RUN. While in CLEAR the external write
// port is ignored and both read ports return zero.
// ---------------------------------------------------------------------------
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en_1,
  input  logic [4:0]  read_addr_1,
  output logic [31:0] read_data_1,
  input  logic        read_en_2,
  input  logic [4:0]  read_addr_2,
  output logic [31:0] read_data_2,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  output logic        busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  clr_ptr_reg, clr_ptr_next;

  logic [31:0] regs_mem [32];

  // Single physical write port shared by the sweep and the external port.
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  // State register. Reset pins the sweep at index 0 for as long as rst is
  // high; the first sweep write happens on the first edge with rst low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= 5'd0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    mem_we       = 1'b0;
    mem_waddr    = write_addr;
    mem_wdata    = write_data;
    case (state_reg)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr_reg;
        mem_wdata    = 32'd0;
        clr_ptr_next = clr_ptr_reg + 5'd1;
        if (clr_ptr_reg == 5'd31) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = write_en && (write_addr != 5'd0);
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // Storage has no reset of its own; the sweep zeroes it. A write that
  // coincides with rst is dropped, whatever state we are in.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      regs_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy = (state_reg == ST_CLEAR);

  // Two identical read ports.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic        en_c;
      logic [4:0]  addr_c;
      logic [31:0] data_c;

      assign en_c   = (gi == 0) ? read_en_1   : read_en_2;
      assign addr_c = (gi == 0) ? read_addr_1 : read_addr_2;

      always_comb begin
        data_c = 32'd0;
        // Index 0 never reads nonzero, bypass included, because the
        // address check gates everything below it.
        if ((state_reg == ST_RUN) && en_c && (addr_c != 5'd0)) begin
`ifdef REG_FILE_BYPASS_EN
          // Forward only a write that will actually land this edge.
          if (write_en && !rst && (write_addr == addr_c)) begin
            data_c = write_data;
          end else begin
            data_c = regs_mem[addr_c];
          end
`else
          data_c = regs_mem[addr_c];
`endif
        end
      end
    end
  endgenerate

  assign read_data_1 = g_rd[0].data_c;
  assign read_data_2 = g_rd[1].data_c;

endmodule
